uart_tx_sequencer: RTL and testbench
====================================

// Module: uart_tx_sequencer
// PURPOSE
//  UART transmit controller built around a baud-tick divider.
//  - Accepts one byte per start request and sequences start, data and stop bits on a serial line.
//  - Each bit is held for exactly one baud period.
//  - Selects between two divisor settings (e.g. 9600 bps, or 16x-oversample rate at 50 MHz),
//    latched per frame.
//  - Sits between the command/host logic and the serial output pin.
// PARAMETERS
//  CLK_DIV_SLOW  5208  sysclk cycles per bit when baud_sel=0 (>=2)
//  CLK_DIV_FAST  326   sysclk cycles per bit when baud_sel=1 (>=2)
//  DATA_BITS     8     data bits per frame, LSB first (1..8)
// PORTS
//  sysclk    in   1          system clock, all logic on rising edge
//  reset     in   1          synchronous, active-high reset
//  tx_start  in   1          request: send tx_data; sampled only in IDLE
//  tx_data   in   DATA_BITS  byte to send; captured in the accept cycle
//  baud_sel  in   1          0=CLK_DIV_SLOW, 1=CLK_DIV_FAST; captured in the accept cycle
//  tx        out  1          serial line, idle high
//  tx_busy   out  1          high from the cycle after accept until the frame ends
//  tx_done   out  1          one-cycle pulse in the first IDLE cycle after the stop bit
// BEHAVIOUR
//  - Reset (sync, any state): state=IDLE, tx=1, tx_busy=0, tx_done=0, bit counter=0, baud counter=0.
//    Reset mid-frame aborts the frame; tx=1 from the next cycle; no tx_done.
//  - Accept: state==IDLE && tx_start==1 in cycle N. At the edge ending N:
//    - latch tx_data into the shift register and the selected divisor into div_r;
//    - state<=START, tx<=0, tx_busy<=1, baud_cnt<=0.
//  - Baud counter: counts 0..div_r-1 and wraps to 0. tick=(baud_cnt==div_r-1).
//    It counts only when not IDLE and is held at 0 in IDLE.
//  - FSM (all transitions on tick, all outputs registered):
//    - IDLE  -> START on accept.
//    - START -> DATA: tx<=shift[0]; bit_cnt<=0.
//    - DATA:
//      - if bit_cnt<DATA_BITS-1: shift right, tx<=next bit, bit_cnt++;
//      - else -> STOP, tx<=1.
//    - STOP  -> IDLE: tx_busy<=0, tx_done<=1 for one cycle.
//  - Timing:
//    - Frame = (DATA_BITS+2)*div_r cycles; tx_busy high for exactly that long, starting cycle N+1.
//    - tx low in cycles N+1..N+div_r; data bit k occupies cycles N+1+(k+1)*div_r .. +div_r-1.
//  - tx_start while busy: ignored, not queued. The tx_data/baud_sel change mid-frame has no effect.
//  - Back-to-back: tx_start in the tx_done cycle (already IDLE) is accepted, so there is
//    exactly one idle-high cycle between frames.
//  - Width: baud_cnt width = $clog2(max(CLK_DIV_SLOW,CLK_DIV_FAST)). The bit counter is 3 bits.
//    There is no overflow path.
// STRUCTURE
//  - Shared package/include uart_pkg: FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2,
//    STOP=2'd3) and default divisor constants (DIV_9600_50M=5208, DIV_9600X16_50M=326).
//  - Sub-module baud_tick_gen:
//    - inputs sysclk, reset, en, div;
//    - output tick (one-cycle pulse every div cycles while en);
//    - restarts from 0 whenever en=0.
//  - Top holds the FSM, shift register and bit counter; all outputs come from flops.
// TESTING  (bench: CLK_DIV_SLOW=8, CLK_DIV_FAST=4, DATA_BITS=8, sysclk period 2 ns)
//  1. Reset held 3 cycles, then released, no start -> tx=1, tx_busy=0, tx_done=0 for 50 cycles.
//  2. tx_start pulse with tx_data=8'hA5, baud_sel=0:
//     - tx bit-stream 0,1,0,1,0,0,1,0,1,1, each held 8 cycles;
//     - tx_busy high for 80 cycles;
//     - tx_done one pulse at cycle N+81.
//  3. tx_data=8'h3C, baud_sel=1 -> each bit held 4 cycles, frame 40 cycles, sampled byte=8'h3C.
//  4. tx_start re-pulsed mid-frame with tx_data=8'hFF and baud_sel toggled
//     -> frame unchanged, no second frame, a single tx_done.
//  5. tx_start held high continuously with tx_data=8'h00
//     -> consecutive frames separated by exactly 1 idle-high cycle; tx_done once per frame.
//  6. reset asserted at the 3rd data bit of an 8'h55 frame
//     -> next cycle tx=1, tx_busy=0; no tx_done; a new start after release sends a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default baud divisors for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int DIV_9600_50M = 5208;
  localparam int DIV_9600X16_50M = 326;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: host-side request/status bundle and serial line of the UART transmitter
interface uart_tx_sequencer_if #(parameter int DATA_BITS = 8);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 baud_sel;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;
  modport master (output tx_start, tx_data, baud_sel, input tx, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, baud_sel, output tx, tx_busy, tx_done);
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-cycle tick every div cycles while en, restarting from 0 when disabled
module baud_tick_gen #(
  parameter int CW = 13
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        en,
  input  logic [CW:0] div,
  output logic        tick
);
  logic [CW-1:0] r_cnt;
  assign tick = en && ({1'b0, r_cnt} == div - 1'b1);
  always_ff @(posedge sysclk)
    r_cnt <= (reset || !en || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: frames one byte per request as start/data/stop bits, one baud period each
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int CLK_DIV_SLOW = DIV_9600_50M,
  parameter int CLK_DIV_FAST = DIV_9600X16_50M,
  parameter int DATA_BITS    = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  uart_tx_sequencer_if.slave   bus
);
  localparam int CW = $clog2(max_int(CLK_DIV_SLOW, CLK_DIV_FAST));
  // one extra bit so a power-of-two divisor still fits
  localparam logic [CW:0] DIV_S = CLK_DIV_SLOW[CW:0];
  localparam logic [CW:0] DIV_F = CLK_DIV_FAST[CW:0];
  state_t               r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [2:0]           r_bit, w_bit;
  logic [CW:0]          r_div, w_div;
  logic                 r_tx, w_tx, r_busy, w_busy, r_done, w_done, w_tick, w_en;
  assign w_en = r_state != IDLE;
  baud_tick_gen #(.CW(CW)) u_baud (
    .sysclk (sysclk),
    .reset  (reset),
    .en     (w_en),
    .div    (r_div),
    .tick   (w_tick)
  );
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_div   = r_div;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (bus.tx_start) begin
        w_state = START;
        w_shift = bus.tx_data;
        w_div   = bus.baud_sel ? DIV_F : DIV_S;
        w_tx    = 1'b0;
        w_busy  = 1'b1;
      end
      START: if (w_tick) begin
        w_state = DATA;
        w_tx    = r_shift[0];
        w_bit   = 3'd0;
      end
      DATA: if (w_tick) begin
        if (r_bit < 3'(DATA_BITS - 1)) begin
          w_shift = r_shift >> 1;
          w_tx    = w_shift[0];
          w_bit   = r_bit + 3'd1;
        end else begin
          w_state = STOP;
          w_tx    = 1'b1;
        end
      end
      STOP: if (w_tick) begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= 3'd0;
      r_div   <= DIV_S;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_div   <= w_div;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: table-driven frame checks plus reset-abort and back-to-back sequences
module tb_uart_tx_sequencer;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  always #1 sysclk = ~sysclk;
  uart_tx_sequencer_if #(.DATA_BITS(8)) bus ();
  uart_tx_sequencer #(.CLK_DIV_SLOW(8), .CLK_DIV_FAST(4), .DATA_BITS(8)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );
  typedef struct {
    logic [7:0] data;
    logic       sel;
    int         div;
    logic [9:0] stream;
    int         frames;
    bit         mid;
  } vec_t;
  vec_t vecs[4];
  int n_pass = 0;
  int n_total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic idle_check(input string name, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      @(negedge sysclk);
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) ok = 1'b0;
    end
    check(name, 32'(ok), 32'd1);
  endtask
  task automatic start_frame(input vec_t v);
    bus.tx_start = 1'b1;
    bus.tx_data  = v.data;
    bus.baud_sel = v.sel;
  endtask
  // entered at the negedge of the accept cycle, returns at the negedge of the tx_done cycle
  task automatic check_frame(input vec_t v);
    logic [7:0] samp = '0;
    bit ok;
    @(negedge sysclk);
    if (v.frames == 1) bus.tx_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < v.div; j++) begin
        if (bus.tx !== v.stream[b] || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) ok = 1'b0;
        if (b >= 1 && b <= 8 && j == v.div / 2) samp[b-1] = bus.tx;
        if (v.mid && b == 2 && j == 0) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = 8'hFF;
          bus.baud_sel = ~v.sel;
        end
        if (v.mid && b == 3 && j == 0) bus.tx_start = 1'b0;
        @(negedge sysclk);
      end
      check($sformatf("bit%0d_of_%02h", b, v.data), 32'(ok), 32'd1);
    end
    check($sformatf("byte_%02h", v.data), 32'(samp), 32'(v.data));
    check($sformatf("done_%02h", v.data), 32'(bus.tx_done), 32'd1);
    check($sformatf("busy_end_%02h", v.data), 32'(bus.tx_busy), 32'd0);
    check($sformatf("tx_end_%02h", v.data), 32'(bus.tx), 32'd1);
  endtask
  initial begin
    vec_t v55;
    vecs[0] = '{8'hA5, 1'b0, 8, 10'b1101001010, 1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 4, 10'b1001111000, 1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 8, 10'b1001111000, 1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 4, 10'b1000000000, 2, 1'b0};
    v55     = '{8'h55, 1'b0, 8, 10'b1010101010, 1, 1'b0};
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    bus.baud_sel = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_done", 32'(bus.tx_done), 32'd0);
    reset = 1'b0;
    idle_check("idle_50", 50);
    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i]);
      for (int f = 0; f < vecs[i].frames; f++) check_frame(vecs[i]);
      bus.tx_start = 1'b0;
      idle_check($sformatf("idle_after_vec%0d", i), 6);
    end
    // abort an 8'h55 frame during its third data bit
    start_frame(v55);
    @(negedge sysclk);
    bus.tx_start = 1'b0;
    repeat (26) @(negedge sysclk);
    check("abort_pre_tx", 32'(bus.tx), 32'd1);
    check("abort_pre_busy", 32'(bus.tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge sysclk);
    check("abort_tx", 32'(bus.tx), 32'd1);
    check("abort_busy", 32'(bus.tx_busy), 32'd0);
    check("abort_done", 32'(bus.tx_done), 32'd0);
    reset = 1'b0;
    idle_check("abort_idle", 20);
    start_frame(v55);
    check_frame(v55);
    bus.tx_start = 1'b0;
    idle_check("idle_after_55", 6);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
